// File: rtl/mdu_seq_pkg.sv
// Shared types for the sequential multiply/divide unit: funct3 op codes,
// FSM states and the default datapath width.
package mdu_seq_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative datapath: shift-add for multiply,
// restoring subtract for divide. Accumulator is {hi, lo}.
module mdu_step
    import mdu_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              i_div,
    input  logic [XLEN-1:0]   i_opnd,
    input  logic [2*XLEN-1:0] i_acc,
    output logic [2*XLEN-1:0] o_acc
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;

    always_comb begin
        sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        // Partial remainder shifted left with the next dividend bit, minus divisor.
        diff = i_acc[2*XLEN-1:XLEN-1] - {1'b0, i_opnd};
        if (!i_div)
            o_acc = {sum, i_acc[XLEN-1:1]};
        else if (!diff[XLEN])
            o_acc = {diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
        else
            o_acc = {i_acc[2*XLEN-2:0], 1'b0};
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: magnitudes are iterated for XLEN
// cycles, then signs are fixed up and the requested half is registered.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    funct3_e           op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    funct3_e           in_op;
    logic              sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0]   abs_a, abs_b, sel;
    logic [2*XLEN-1:0] prod, step_acc;
    logic              calc_div;

    assign calc_div = op_q[2];

    mdu_step #(.XLEN(XLEN)) u_step (
        .i_div (calc_div),
        .i_opnd(opnd_q),
        .i_acc (acc_q),
        .o_acc (step_acc)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;

        in_op = funct3_e'(i_funct3);
        sgn_a = in_op inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        sgn_b = in_op inside {F3_MULH, F3_DIV, F3_REM};
        neg_a = sgn_a & i_op_a[XLEN-1];
        neg_b = sgn_b & i_op_b[XLEN-1];
        abs_a = neg_a ? -i_op_a : i_op_a;
        abs_b = neg_b ? -i_op_b : i_op_b;
        prod  = neg_q ? -acc_q : acc_q;
        sel   = (op_q inside {F3_DIV, F3_DIVU}) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];

        case (state_q)
            ST_IDLE: if (i_valid) begin
                op_d = in_op;
                // funct3 bit 2 = divide class, bit 1 = remainder within it
                if (in_op[2] && i_op_b == '0) begin
                    result_d = in_op[1] ? i_op_a : '1;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (sgn_b && in_op[2] && i_op_a == SMIN && i_op_b == '1) begin
                    result_d = in_op[1] ? '0 : SMIN;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    opnd_d  = in_op[2] ? abs_b : abs_a;
                    acc_d   = {{XLEN{1'b0}}, (in_op[2] ? abs_a : abs_b)};
                    neg_d   = (in_op == F3_REM) ? neg_a : (neg_a ^ neg_b);
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1))
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                if (!op_q[2])
                    result_d = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                else
                    result_d = neg_q ? -sel : sel;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (i_flush) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            op_q     <= F3_MUL;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign o_stall  = (state_q == ST_IDLE && i_valid) || state_q == ST_CALC || state_q == ST_FIX;
    assign o_done   = done_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized and directed bench for mdu_seq against a plain-arithmetic
// RV32M reference model.
module tb_mdu_seq;

    logic        i_clk = 1'b0;
    logic        i_reset, i_valid, i_flush;
    logic [2:0]  i_funct3;
    logic [31:0] i_op_a, i_op_b;
    logic        o_stall, o_done;
    logic [31:0] o_result;

    int n_vec = 0;
    int n_err = 0;

    mdu_seq #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_funct3(i_funct3),
        .i_op_a(i_op_a), .i_op_b(i_op_b), .i_flush(i_flush),
        .o_stall(o_stall), .o_done(o_done), .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = {32'h0, a};
        longint      ub = {32'h0, b};
        logic [63:0] p;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, measure latency and stall cycles, then watch `extra`
    // cycles for stray done pulses. `poke` > 0 raises i_valid mid-calculation.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int poke, input int extra);
        int lat, stl, n;
        bit special;
        special = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        @(negedge i_clk);
        i_valid = 1'b1; i_funct3 = f; i_op_a = a; i_op_b = b;
        #1;
        stl = o_stall ? 1 : 0;
        lat = 0;
        while (lat < 100) begin
            @(negedge i_clk);
            lat++;
            i_valid = (lat == poke);
            if (lat == poke) begin
                i_funct3 = 3'($urandom); i_op_a = $urandom; i_op_b = $urandom;
            end
            #1;
            if (o_done) break;
            if (o_stall) stl++;
        end
        chk("latency", lat, special ? 1 : 34);
        chk("stall_cycles", stl, special ? 1 : 34);
        chk("result", o_result, exp);
        chk("stall_in_done", o_stall, 0);
        n = 0;
        repeat (extra) begin
            @(negedge i_clk); #1;
            if (o_done) n++;
        end
        chk("extra_done", n, 0);
        chk("result_hold", o_result, exp);
    endtask

    initial begin
        int n;
        logic [2:0]  f;
        logic [31:0] a, b;
        i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
        i_funct3 = 3'd0; i_op_a = '0; i_op_b = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_done", o_done, 0);
        chk("rst_result", o_result, 0);
        chk("rst_stall", o_stall, 0);
        i_reset = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, 1);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 1);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 1);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 0, 1);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 0, 1);
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1);
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 0, 1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 1);

        // flush mid-calculation, then a fresh op
        @(negedge i_clk);
        i_valid = 1'b1; i_funct3 = 3'd0; i_op_a = 32'd9; i_op_b = 32'd11;
        @(negedge i_clk); i_valid = 1'b0;
        repeat (9) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk); i_flush = 1'b0; #1;
        chk("flush_stall", o_stall, 0);
        chk("flush_done", o_done, 0);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 0, 1);

        // flush wins over a same-cycle request
        @(negedge i_clk);
        i_flush = 1'b1; i_valid = 1'b1; i_funct3 = 3'd5; i_op_a = 32'd50; i_op_b = 32'd5;
        @(negedge i_clk); i_flush = 1'b0; i_valid = 1'b0; #1;
        chk("flush_prio_stall", o_stall, 0);
        n = 0;
        repeat (40) begin @(negedge i_clk); #1; if (o_done) n++; end
        chk("flush_prio_done", n, 0);

        // reset mid-calculation
        @(negedge i_clk);
        i_valid = 1'b1; i_funct3 = 3'd4; i_op_a = 32'd1000; i_op_b = 32'd3;
        @(negedge i_clk); i_valid = 1'b0;
        repeat (19) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk); i_reset = 1'b0; #1;
        chk("rst_mid_result", o_result, 0);
        chk("rst_mid_done", o_done, 0);
        chk("rst_mid_stall", o_stall, 0);
        n = 0;
        repeat (40) begin @(negedge i_clk); #1; if (o_done) n++; end
        chk("rst_mid_no_done", n, 0);

        // i_valid during CALC must be ignored
        run_op(3'd1, 32'h1234_5678, 32'h8765_4321, ref_res(3'd1, 32'h1234_5678, 32'h8765_4321), 5, 40);

        for (int k = 0; k < 150; k++) begin
            f = 3'($urandom);
            a = pick();
            b = pick();
            if ($urandom_range(0, 4) == 0)
                run_op(f, a, b, ref_res(f, a, b), $urandom_range(2, 30), 40);
            else
                run_op(f, a, b, ref_res(f, a, b), 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
